data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_tag_array.sv | 52 +++++
 rtl/data_cache.sv | 161 ++++++++++++++++
 tb/tb_data_cache.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// FSM states, bus widths and address-split width helpers.
package dcache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_t;

  function automatic int unsigned index_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned lines);
    return ADDR_W - OFFSET_W - BYTE_OFF_W - index_w(lines);
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid, dirty and tag storage for the direct-mapped cache; one combinational
// lookup port plus fill and dirty-set write ports.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 8,
  localparam int unsigned IDX_W = index_w(LINES),
  localparam int unsigned TAG_W = tag_w(LINES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic             dirty_out,
  output logic [TAG_W-1:0] stored_tag,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             dirty_set_en,
  input  logic [IDX_W-1:0] dirty_set_idx
);

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
        dirty[fill_idx] <= 1'b0;
      end
      if (dirty_set_en) dirty[dirty_set_idx] <= 1'b1;
    end
  end

  // Tags need no reset: an entry is only trusted while its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) tags[fill_idx] <= fill_tag;
  end

  always_comb begin
    stored_tag = tags[lookup_idx];
    hit        = valid[lookup_idx] && (stored_tag == lookup_tag);
    dirty_out  = valid[lookup_idx] && dirty[lookup_idx];
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache with a 128-bit block bus.
// Optional hit/miss counters are added when DCACHE_STATS_EN is defined.
module data_cache
  import dcache_pkg::*;
#(
  parameter int unsigned LINES          = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITEDATA,
  output logic [31:0]  READDATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int unsigned IDX_W = index_w(LINES);
  localparam int unsigned TAG_W = tag_w(LINES);
  localparam int unsigned LINE_W = WORDS_PER_LINE * WORD_W;

  state_t state, next_state;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] off;
  logic                req;
  logic                hit;
  logic                dirty_out;
  logic [TAG_W-1:0]    stored_tag;
  logic                miss_start;
  logic                idle_hit;
  logic                addr_unused;

  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] fill_buf;
  logic [LINE_W-1:0] data_mem [LINES];

  assign idx         = ADDRESS[4 +: IDX_W];
  assign tag         = ADDRESS[ADDR_W-1 -: TAG_W];
  assign off         = ADDRESS[3:2];
  assign req         = READ | WRITE;
  assign idle_hit    = (state == IDLE) && hit;
  assign addr_unused = ^ADDRESS[1:0];

  dcache_tag_array #(.LINES(LINES)) u_tags (
    .clk           (CLK),
    .reset         (RESET),
    .lookup_idx    (idx),
    .lookup_tag    (tag),
    .hit           (hit),
    .dirty_out     (dirty_out),
    .stored_tag    (stored_tag),
    .fill_en       (state == UPDATE),
    .fill_idx      (miss_idx),
    .fill_tag      (miss_tag),
    .dirty_set_en  (idle_hit && WRITE),
    .dirty_set_idx (idx)
  );

  assign READDATA = hit ? data_mem[idx][{off, 5'b0} +: WORD_W] : '0;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Miss address and victim tag are captured so a dropped request still fills.
  always_comb begin
    next_state    = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    miss_start    = 1'b0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          BUSYWAIT   = 1'b1;
          miss_start = 1'b1;
          next_state = dirty_out ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = req;
        MEM_WRITE     = !RESET;
        MEM_ADDRESS   = {victim_tag, miss_idx};
        MEM_WRITEDATA = data_mem[miss_idx];
        if (!MEM_BUSYWAIT) next_state = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = req;
        MEM_READ    = !RESET;
        MEM_ADDRESS = {miss_tag, miss_idx};
        if (!MEM_BUSYWAIT) next_state = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT   = req;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (miss_start) begin
      miss_idx   <= idx;
      miss_tag   <= tag;
      victim_tag <= stored_tag;
    end
    if (state == FETCH && !MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
  end

  always_ff @(posedge CLK) begin
    if (state == UPDATE)
      data_mem[miss_idx] <= fill_buf;
    else if (idle_hit && WRITE)
      data_mem[idx][{off, 5'b0} +: WORD_W] <= WRITEDATA;
  end

`ifdef DCACHE_STATS_EN
  logic        was_busy;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // A hit only counts when the previous cycle did not stall, so the
  // completing cycle of a serviced miss is not counted twice.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      was_busy <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      was_busy <= BUSYWAIT;
      if (idle_hit && req && !was_busy && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (miss_start && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign HIT_COUNT  = hit_cnt;
  assign MISS_COUNT = miss_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a flat-memory reference predicts load data
// and stall lengths; a separate monitor pops and compares on each completion.
module tb_data_cache;

  localparam int LINES = 8;

  logic         CLK = 1'b0;
  logic         RESET, READ, WRITE;
  logic [31:0]  ADDRESS, WRITEDATA, READDATA;
  logic         BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;
  logic         MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

  data_cache #(.LINES(LINES), .WORDS_PER_LINE(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    int          stall;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit           is_wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } mlog_t;
  mlog_t mlog[$];

  // Main memory contents written back by the DUT; untouched blocks hold a pattern.
  logic [127:0] mem_blk [logic [27:0]];
  int lat = 0;
  bit mon_en = 1'b1;

  // Reference: flat word memory plus a tag/valid/dirty view for stall prediction.
  logic [31:0] overlay [logic [29:0]];
  bit          mvalid [LINES];
  bit          mdirty [LINES];
  logic [24:0] mtag   [LINES];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  function automatic logic [31:0] pat_word(input logic [29:0] w);
    return {2'b00, w} * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] w);
    logic [127:0] b;
    if (mem_blk.exists(w[29:2])) begin
      b = mem_blk[w[29:2]];
      return b[w[1:0]*32 +: 32];
    end
    return pat_word(w);
  endfunction

  function automatic logic [127:0] block_of(input logic [27:0] blk);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = mem_word({blk, 2'(i)});
    return b;
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] w);
    if (overlay.exists(w)) return overlay[w];
    return pat_word(w);
  endfunction

  // Reset loses every dirty line: the truth becomes what memory holds.
  task automatic model_reset();
    logic [127:0] b;
    overlay.delete();
    foreach (mem_blk[k]) begin
      b = mem_blk[k];
      for (int i = 0; i < 4; i++) overlay[{k, 2'(i)}] = b[i*32 +: 32];
    end
    for (int i = 0; i < LINES; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int l, input string name);
    exp_t        e;
    int          idx = int'(addr[6:4]);
    logic [24:0] t   = addr[31:7];
    logic [29:0] w   = addr[31:2];
    bit          hit = mvalid[idx] && (mtag[idx] == t);
    int          n   = 0;
    e.is_read = rd && !wr;
    e.data    = ref_read(w);
    e.name    = name;
    e.stall   = hit ? 0 : (mvalid[idx] && mdirty[idx]) ? 2*l + 4 : l + 3;
    sb.push_back(e);
    if (!hit) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = t;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      overlay[w]  = wdata;
      mdirty[idx] = 1'b1;
    end
    lat = l;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    forever begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      n++;
      if (n > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL %s: BUSYWAIT still high after %0d cycles, expected release", name, n);
        summary();
        $finish;
      end
    end
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  // Memory responder: lat busy cycles, then one completing cycle.
  initial begin
    int cnt = 0;
    mlog_t m;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    forever begin
      @(posedge CLK); #1;
      if (RESET || !(MEM_READ || MEM_WRITE)) begin
        cnt = 0;
        MEM_BUSYWAIT = 1'b0;
      end else if (cnt < lat) begin
        cnt++;
        MEM_BUSYWAIT = 1'b1;
      end else begin
        cnt = 0;
        MEM_BUSYWAIT = 1'b0;
        m.is_wr = MEM_WRITE;
        m.addr  = MEM_ADDRESS;
        m.data  = MEM_WRITE ? MEM_WRITEDATA : '0;
        if (MEM_WRITE) mem_blk[MEM_ADDRESS] = MEM_WRITEDATA;
        else           MEM_READDATA = block_of(MEM_ADDRESS);
        mlog.push_back(m);
      end
    end
  end

  // Monitor: counts stall cycles and pops the scoreboard on every completion.
  initial begin
    int stall = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) begin
        miscompares++;
        $display("FAIL mem_exclusive: got MEM_READ=1 MEM_WRITE=1 expected at most one");
      end
      if (mon_en && !RESET && (READ || WRITE)) begin
        if (BUSYWAIT) stall++;
        else if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard: got completion expected none pending");
          stall = 0;
        end else begin
          e = sb.pop_front();
          check({e.name, " stall"}, 128'(stall), 128'(e.stall));
          if (e.is_read) check({e.name, " data"}, 128'(READDATA), 128'(e.data));
          stall = 0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    vectors++;
    miscompares++;
    $display("FAIL watchdog: got no end of test expected completion");
    summary();
    $finish;
  end

  initial begin
    int n;
    logic [31:0] a;
    int k;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset BUSYWAIT", 128'(BUSYWAIT), 128'(0));
    check("reset MEM_READ", 128'(MEM_READ), 128'(0));
    check("reset MEM_WRITE", 128'(MEM_WRITE), 128'(0));
    check("reset READDATA", 128'(READDATA), 128'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Cold read miss, 5 busy memory cycles.
    mlog.delete();
    do_req(1, 0, 32'h0000_0040, 32'h0, 5, "rd40");
    check("rd40 transfers", 128'(mlog.size()), 128'(1));
    if (mlog.size() >= 1) begin
      check("rd40 fetch kind", 128'(mlog[0].is_wr), 128'(0));
      check("rd40 fetch addr", 128'(mlog[0].addr), 128'(28'h000_0004));
    end

    do_req(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, 5, "wr44");
    do_req(1, 0, 32'h0000_0044, 32'h0, 5, "rd44");
    check("hit no transfers", 128'(mlog.size()), 128'(1));

    // Conflict miss on a dirty line: write-back then fetch.
    mlog.delete();
    do_req(1, 0, 32'h0000_1040, 32'h0, 2, "rd1040");
    check("rd1040 transfers", 128'(mlog.size()), 128'(2));
    if (mlog.size() >= 2) begin
      check("wb kind", 128'(mlog[0].is_wr), 128'(1));
      check("wb addr", 128'(mlog[0].addr), 128'(28'h000_0004));
      check("wb word1", 128'(mlog[0].data[63:32]), 128'(32'hDEAD_BEEF));
      check("fetch kind", 128'(mlog[1].is_wr), 128'(0));
      check("fetch addr", 128'(mlog[1].addr), 128'(28'h000_0104));
    end
`ifdef DCACHE_STATS_EN
    check("HIT_COUNT", 128'(HIT_COUNT), 128'(2));
    check("MISS_COUNT", 128'(MISS_COUNT), 128'(2));
`endif

    // Reset in the middle of a fetch.
    mon_en = 1'b0;
    lat = 5;
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = 32'h0000_2080;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!MEM_READ && n < 20);
    check("fetch started", 128'(MEM_READ), 128'(1));
    @(posedge CLK); #1;
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("abort MEM_READ", 128'(MEM_READ), 128'(0));
    check("abort BUSYWAIT", 128'(BUSYWAIT), 128'(0));
    check("abort READDATA", 128'(READDATA), 128'(0));
    model_reset();
    mon_en = 1'b1;
    do_req(1, 0, 32'h0000_2080, 32'h0, 1, "rd2080 after reset");
    do_req(1, 0, 32'h0000_0044, 32'h0, 0, "rd44 after reset");

    // Randomized traffic over a few tags per index to mix hits and evictions.
    for (int i = 0; i < 250; i++) begin
      a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      k = $urandom_range(0, 9);
      if (k < 5)      do_req(1, 0, a, $urandom, $urandom_range(0, 3), "rand rd");
      else if (k < 9) do_req(0, 1, a, $urandom, $urandom_range(0, 3), "rand wr");
      else            do_req(1, 1, a, $urandom, $urandom_range(0, 3), "rand rdwr");
    end

    repeat (3) @(posedge CLK);
    check("scoreboard drained", 128'(sb.size()), 128'(0));
    summary();
    $finish;
  end

endmodule
